// File: rtl/exe_muldiv_ctrl_if.sv
// Request/response bundle between the EX stage, the mul/div units and
// the mul/div sequencer.
`ifndef ALUCTL_WIDTH
`define ALUCTL_WIDTH 5
`endif

interface exe_muldiv_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int CTL_W  = `ALUCTL_WIDTH
);
    logic              I_valid;
    logic [CTL_W-1:0]  I_alu_ctrl;
    logic              I_flush;
    logic              I_mul_ready;
    logic              I_div_ready;
    logic [DATA_W-1:0] I_alu_result;
    logic              O_mul_start;
    logic              O_div_start;
    logic              O_signed_div;
    logic              O_annul;
    logic              O_stall;
    logic [DATA_W-1:0] O_result;
    logic              O_result_valid;
    logic              O_timeout;

    modport master (
        output I_valid, I_alu_ctrl, I_flush,
        output I_mul_ready, I_div_ready, I_alu_result,
        input  O_mul_start, O_div_start, O_signed_div,
        input  O_annul, O_stall, O_result,
        input  O_result_valid, O_timeout
    );

    modport slave (
        input  I_valid, I_alu_ctrl, I_flush,
        input  I_mul_ready, I_div_ready, I_alu_result,
        output O_mul_start, O_div_start, O_signed_div,
        output O_annul, O_stall, O_result,
        output O_result_valid, O_timeout
    );
endinterface

// File: rtl/exe_muldiv_ctrl.sv
// EX-stage mul/div sequencer: start, stall, annul and result capture.
// Optional busy watchdog is built when MULDIV_TIMEOUT_EN is defined.
`ifndef ALUCTL_WIDTH
`define ALUCTL_WIDTH 5
`endif

module exe_muldiv_ctrl #(
    parameter int DATA_W         = 32,
    parameter int CTL_W          = `ALUCTL_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic              clk,
    input logic              rst,
    exe_muldiv_ctrl_if.slave bus
);
    localparam logic [CTL_W-1:0] ALU_MUL    = CTL_W'(5'h10);
    localparam logic [CTL_W-1:0] ALU_MULH   = CTL_W'(5'h11);
    localparam logic [CTL_W-1:0] ALU_MULHSU = CTL_W'(5'h12);
    localparam logic [CTL_W-1:0] ALU_MULHU  = CTL_W'(5'h13);
    localparam logic [CTL_W-1:0] ALU_DIV    = CTL_W'(5'h14);
    localparam logic [CTL_W-1:0] ALU_DIVU   = CTL_W'(5'h15);
    localparam logic [CTL_W-1:0] ALU_REM    = CTL_W'(5'h16);
    localparam logic [CTL_W-1:0] ALU_REMU   = CTL_W'(5'h17);

    typedef enum logic [1:0] {
        IDLE,
        MUL_BUSY,
        DIV_BUSY,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] result_nxt;
    logic              signed_q;
    logic              is_mul;
    logic              is_div;
    logic              is_sdiv;
    logic              launch;
    logic              busy;
    logic              ready;
    logic              tmo_hit;
    logic              mul_start;
    logic              div_start;
    logic              signed_div;
    logic              annul;
    logic              stall;
    logic              result_valid;
    logic              tmo_fire;

    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_sdiv = 1'b0;
        unique case (1'b1)
            bus.I_alu_ctrl inside {ALU_MUL, ALU_MULH,
                                   ALU_MULHSU, ALU_MULHU}:
                is_mul = 1'b1;
            bus.I_alu_ctrl inside {ALU_DIV, ALU_REM}: begin
                is_div  = 1'b1;
                is_sdiv = 1'b1;
            end
            bus.I_alu_ctrl inside {ALU_DIVU, ALU_REMU}:
                is_div = 1'b1;
            default: ;
        endcase
    end

    // rst gates the launch so every output reads 0 while reset is held
    assign launch = rst && bus.I_valid && (is_mul || is_div)
                    && !bus.I_flush;
    assign busy   = (state == MUL_BUSY) || (state == DIV_BUSY);
    assign ready  = (state == MUL_BUSY) ? bus.I_mul_ready
                                        : bus.I_div_ready;

`ifdef MULDIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == IDLE && launch) begin
            cnt <= '0;
        end else if (busy) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // fires in the busy cycle that brings the count to TIMEOUT_CYCLES
    assign tmo_hit = busy
                     && (cnt + CNT_W'(1) == CNT_W'(TIMEOUT_CYCLES));
`else
    logic unused_cfg;

    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        result_nxt   = result_q;
        mul_start    = 1'b0;
        div_start    = 1'b0;
        signed_div   = 1'b0;
        annul        = 1'b0;
        stall        = 1'b0;
        result_valid = 1'b0;
        tmo_fire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt  = is_mul ? MUL_BUSY : DIV_BUSY;
                    stall      = 1'b1;
                    signed_div = is_sdiv;
                end
            end
            MUL_BUSY, DIV_BUSY: begin
                signed_div = signed_q;
                if (bus.I_flush) begin
                    annul     = (state == DIV_BUSY);
                    state_nxt = IDLE;
                end else begin
                    mul_start = (state == MUL_BUSY);
                    div_start = (state == DIV_BUSY);
                    stall     = 1'b1;
                    if (ready) begin
                        result_nxt = bus.I_alu_result;
                        state_nxt  = DONE;
                    end else if (tmo_hit) begin
                        annul      = 1'b1;
                        tmo_fire   = 1'b1;
                        result_nxt = '1;
                        state_nxt  = DONE;
                    end
                end
            end
            DONE: begin
                result_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            result_q <= '0;
            signed_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            result_q <= result_nxt;
            if (state == IDLE && launch) begin
                signed_q <= is_sdiv;
            end
        end
    end

    assign bus.O_mul_start    = mul_start;
    assign bus.O_div_start    = div_start;
    assign bus.O_signed_div   = signed_div;
    assign bus.O_annul        = annul;
    assign bus.O_stall        = stall;
    assign bus.O_result       = result_q;
    assign bus.O_result_valid = result_valid;
    assign bus.O_timeout      = tmo_fire;
endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Directed + randomized bench for exe_muldiv_ctrl with an ALU
// arithmetic model; watchdog path checked when MULDIV_TIMEOUT_EN is set.
module tb_exe_muldiv_ctrl;
    localparam logic [4:0] C_ADD    = 5'h00;
    localparam logic [4:0] C_MUL    = 5'h10;
    localparam logic [4:0] C_MULH   = 5'h11;
    localparam logic [4:0] C_MULHSU = 5'h12;
    localparam logic [4:0] C_MULHU  = 5'h13;
    localparam logic [4:0] C_DIV    = 5'h14;
    localparam logic [4:0] C_DIVU   = 5'h15;
    localparam logic [4:0] C_REM    = 5'h16;
    localparam logic [4:0] C_REMU   = 5'h17;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [31:0] last_res = '0;

    exe_muldiv_ctrl_if bus ();

    exe_muldiv_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [4:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            C_MUL:    return a * b;
            C_MULH:   begin p = sa * sb; return p[63:32]; end
            C_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            C_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            C_DIV:    return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            C_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            C_REM:    return (b == 0) ? a : 32'(sa % sb);
            C_REMU:   return (b == 0) ? a : a % b;
            default:  return 32'h0;
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.I_valid      = 1'($urandom_range(0, 1));
            bus.I_alu_ctrl   = C_ADD;
            bus.I_flush      = 1'b0;
            bus.I_mul_ready  = 1'($urandom_range(0, 1));
            bus.I_div_ready  = 1'($urandom_range(0, 1));
            bus.I_alu_result = $urandom;
            #1;
            chk("idle_stall", 32'(bus.O_stall), 0);
            chk("idle_start", {bus.O_mul_start, bus.O_div_start}, 0);
            chk("idle_valid", 32'(bus.O_result_valid), 0);
            chk("idle_result", bus.O_result, last_res);
        end
    endtask

    // launch cycle, lat busy cycles (ready on the last), then DONE;
    // flush_at>0 kills the op in that busy cycle instead
    task automatic run_op(input logic [4:0] op, input int lat,
                          input int flush_at, input bit flush_done,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        bit is_d;
        bit sgn;
        is_d    = (op inside {C_DIV, C_DIVU, C_REM, C_REMU});
        sgn     = (op inside {C_DIV, C_REM});
        exp_res = alu_model(op, a, b);
        @(negedge clk);
        bus.I_valid      = 1'b1;
        bus.I_alu_ctrl   = op;
        bus.I_flush      = 1'b0;
        bus.I_mul_ready  = 1'b0;
        bus.I_div_ready  = 1'b0;
        bus.I_alu_result = $urandom;
        #1;
        chk("launch_stall", 32'(bus.O_stall), 1);
        chk("launch_start", {bus.O_mul_start, bus.O_div_start}, 0);
        chk("launch_signed", 32'(bus.O_signed_div), 32'(sgn));
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            bus.I_alu_result = (k == lat) ? exp_res : $urandom;
            bus.I_mul_ready  = !is_d && (k == lat);
            bus.I_div_ready  = is_d && (k == lat);
            bus.I_flush      = (k == flush_at);
            #1;
            if (k == flush_at) begin
                chk("flush_start", {bus.O_mul_start, bus.O_div_start}, 0);
                chk("flush_annul", 32'(bus.O_annul), 32'(is_d));
                chk("flush_valid", 32'(bus.O_result_valid), 0);
                @(negedge clk);
                bus.I_valid     = 1'b0;
                bus.I_flush     = 1'b0;
                bus.I_mul_ready = 1'b0;
                bus.I_div_ready = 1'b0;
                #1;
                chk("postflush_stall", 32'(bus.O_stall), 0);
                chk("postflush_valid", 32'(bus.O_result_valid), 0);
                chk("postflush_annul", 32'(bus.O_annul), 0);
                chk("postflush_result", bus.O_result, last_res);
                return;
            end
            chk("busy_start", {bus.O_mul_start, bus.O_div_start},
                {30'b0, !is_d, is_d});
            chk("busy_stall", 32'(bus.O_stall), 1);
            chk("busy_signed", 32'(bus.O_signed_div), 32'(sgn));
            chk("busy_annul", 32'(bus.O_annul), 0);
            chk("busy_valid", 32'(bus.O_result_valid), 0);
        end
        @(negedge clk);
        bus.I_valid      = 1'b0;
        bus.I_flush      = flush_done;
        bus.I_mul_ready  = 1'($urandom_range(0, 1));
        bus.I_div_ready  = 1'($urandom_range(0, 1));
        bus.I_alu_result = $urandom;
        #1;
        chk("done_valid", 32'(bus.O_result_valid), 1);
        chk("done_result", bus.O_result, exp_res);
        chk("done_stall", 32'(bus.O_stall), 0);
        chk("done_start", {bus.O_mul_start, bus.O_div_start}, 0);
        last_res = exp_res;
    endtask

    initial begin
        bus.I_valid      = 1'b0;
        bus.I_alu_ctrl   = C_ADD;
        bus.I_flush      = 1'b0;
        bus.I_mul_ready  = 1'b0;
        bus.I_div_ready  = 1'b0;
        bus.I_alu_result = '0;
        #12;
        chk("rst_stall", 32'(bus.O_stall), 0);
        chk("rst_start", {bus.O_mul_start, bus.O_div_start}, 0);
        chk("rst_annul", 32'(bus.O_annul), 0);
        chk("rst_valid", 32'(bus.O_result_valid), 0);
        chk("rst_result", bus.O_result, 0);
        chk("rst_timeout", 32'(bus.O_timeout), 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        run_op(C_MUL, 5, 0, 0, 32'd7, 32'd6);
        chk("mul_42", last_res, 32'd42);
        idle(1);
        run_op(C_DIV, 3, 0, 0, -32'sd20, 32'd3);
        chk("div_neg", bus.O_result, 32'hFFFF_FFFA);
        idle(1);
        run_op(C_DIVU, 2, 0, 0, -32'sd20, 32'd3);
        idle(1);
        run_op(C_DIV, 5, 3, 0, 32'd100, 32'd7);
        idle(1);
        run_op(C_MUL, 1, 0, 0, 32'd12345, 32'd678);
        run_op(C_REM, 2, 0, 0, 32'd100, 32'd7);
        run_op(C_MULH, 2, 2, 0, 32'hFFFF_0000, 32'h0001_0000);
        run_op(C_REMU, 1, 0, 1, 32'd9, 32'd0);

        // flush in IDLE must not launch
        @(negedge clk);
        bus.I_valid    = 1'b1;
        bus.I_alu_ctrl = C_DIV;
        bus.I_flush    = 1'b1;
        #1;
        chk("idleflush_stall", 32'(bus.O_stall), 0);
        @(negedge clk);
        bus.I_valid = 1'b0;
        bus.I_flush = 1'b0;
        #1;
        chk("idleflush_start", 32'(bus.O_div_start), 0);
        chk("idleflush_stall2", 32'(bus.O_stall), 0);

        // asynchronous reset in DIV_BUSY
        @(negedge clk);
        bus.I_valid    = 1'b1;
        bus.I_alu_ctrl = C_DIV;
        @(negedge clk);
        #1;
        chk("prerst_start", 32'(bus.O_div_start), 1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_start", {bus.O_mul_start, bus.O_div_start}, 0);
        chk("midrst_stall", 32'(bus.O_stall), 0);
        chk("midrst_signed", 32'(bus.O_signed_div), 0);
        chk("midrst_annul", 32'(bus.O_annul), 0);
        chk("midrst_result", bus.O_result, 0);
        last_res = '0;
        @(negedge clk);
        bus.I_valid = 1'b0;
        rst         = 1'b1;
        run_op(C_MULHU, 3, 0, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        idle(1);

        for (int t = 0; t < 16; t++) begin
            logic [4:0] op;
            int lat;
            int fat;
            logic [31:0] b;
            op  = C_MUL + 5'($urandom_range(0, 7));
            lat = $urandom_range(1, 6);
            fat = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
            b   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            run_op(op, lat, fat, 1'($urandom_range(0, 1)), $urandom, b);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end

        // ready never arrives
        @(negedge clk);
        bus.I_valid    = 1'b1;
        bus.I_alu_ctrl = C_DIVU;
        bus.I_mul_ready = 1'b0;
        bus.I_div_ready = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            #1;
            chk("tmo_stall", 32'(bus.O_stall), 1);
            chk("tmo_fire", 32'(bus.O_timeout), 32'(k == TMO));
            chk("tmo_annul", 32'(bus.O_annul), 32'(k == TMO));
        end
        @(negedge clk);
        bus.I_valid = 1'b0;
        #1;
        chk("tmo_valid", 32'(bus.O_result_valid), 1);
        chk("tmo_result", bus.O_result, 32'hFFFF_FFFF);
        chk("tmo_stall_rel", 32'(bus.O_stall), 0);
        last_res = 32'hFFFF_FFFF;
`else
        for (int k = 1; k <= 3 * TMO; k++) begin
            @(negedge clk);
            #1;
            chk("hang_stall", 32'(bus.O_stall), 1);
            chk("hang_timeout", 32'(bus.O_timeout), 0);
            chk("hang_valid", 32'(bus.O_result_valid), 0);
        end
        @(negedge clk);
        bus.I_flush = 1'b1;
        #1;
        chk("hang_annul", 32'(bus.O_annul), 1);
        @(negedge clk);
        bus.I_flush = 1'b0;
        bus.I_valid = 1'b0;
`endif
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exe_muldiv_ctrl.md
Name: exe_muldiv_ctrl

Overview:
- EX-stage sequencer that initiates multi-cycle multiply and divide operations on the ALU, and waits for completion.
- Decodes the ALU control code, drives the mul/div start, signed and annul lines, and stalls the pipeline until ready returns.
- Captures the ALU result and presents it for exactly one advance cycle.
- Handles pipeline flush mid-operation by annulling the in-flight operation.

Parameters:
- DATA_W, 32, operand/result width (matches RegDataWidth).
- CTL_W, `ALUCTL_WIDTH, ALU control code width.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- I_valid  in  1  EX stage holds a valid instruction.
- I_alu_ctrl  in  CTL_W  ALU control code of the EX instruction.
- I_flush  in  1  pipeline flush; kills the EX instruction.
- I_mul_ready  in  1  multiplier done (level, valid while high).
- I_div_ready  in  1  divider done (level, valid while high).
- I_alu_result  in  DATA_W  ALU result bus.
- O_mul_start  out  1  multiply start, level-held.
- O_div_start  out  1  divide start, level-held.
- O_signed_div  out  1  high for DIV/REM, low for DIVU/REMU.
- O_annul  out  1  cancel the in-flight divide, one-cycle pulse.
- O_stall  out  1  stall request to the pipeline.
- O_result  out  DATA_W  captured mul/div result.
- O_result_valid  out  1  O_result valid; the pipeline advances this cycle.
- O_timeout  out  1  watchdog fired (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - All outputs are 0; O_result=0.
  - The watchdog counter is 0.
- Op classification (combinational):
  - is_mul = ctrl in {MUL, MULH, MULHSU, MULHU}.
  - is_div = ctrl in {DIV, DIVU, REM, REMU}.
  - O_signed_div = ctrl in {DIV, REM}, held for the whole operation.
- IDLE state:
  - If I_valid & (is_mul|is_div) & !I_flush: go to MUL_BUSY or DIV_BUSY.
  - O_stall=1 combinationally in this same cycle.
  - Otherwise stay in IDLE with O_stall=0.
- MUL_BUSY / DIV_BUSY states:
  - The matching start line is 1, O_stall=1.
  - On ready=1: latch I_alu_result into O_result and go to DONE; start drops next cycle.
  - The ready sampled in the first busy cycle counts; minimum latency IDLE→DONE is 2 cycles.
- DONE state:
  - O_result_valid=1, O_stall=0, starts are 0.
  - Always go to IDLE next cycle; the pipeline advances in this cycle.
  - A back-to-back mul/div is seen in the following IDLE cycle.
- Flush while busy (I_flush=1 in MUL_BUSY/DIV_BUSY):
  - Drop start in the same cycle.
  - O_annul=1 for one cycle, only when in DIV_BUSY.
  - Go to IDLE with no result update and no O_result_valid.
  - Flush has priority over a simultaneous ready.
- Flush in DONE: O_result_valid is still driven; the pipeline discards it.
- Flush in IDLE: no start is issued.
- ready observed in IDLE or DONE is ignored.
- Mul and div never overlap; only one start line is high at a time.
- Reset mid-operation: immediate return to IDLE; starts and annul drop asynchronously.

Optional Feature:
- Macro: MULDIV_TIMEOUT_EN.
- When defined:
  - A counter of clog2(TIMEOUT_CYCLES+1) bits clears on entering a busy state and increments each busy cycle.
  - When it reaches TIMEOUT_CYCLES without ready: O_annul pulses for one cycle, O_timeout=1 for one cycle, O_result is set to all-ones.
  - The block then enters DONE, so the pipeline is released.
- When not defined:
  - No counter is built; O_timeout is tied 0.
  - The block waits indefinitely for ready.

Test Plan:
- MUL, srca=7, srcb=6, ready at busy cycle 5 → O_stall high for 6 cycles; O_result=42 with O_result_valid for 1 cycle; start low afterwards.
- DIV signed, srca=-20, srcb=3 → O_signed_div=1 throughout; result 0xFFFFFFFA captured on ready; DIVU of the same operands → O_signed_div=0.
- DIV with I_flush at busy cycle 3 → O_annul pulses once, O_div_start drops the same cycle, no O_result_valid, state IDLE; O_result keeps its prior value.
- Back-to-back MUL then REM → DONE for 1 cycle, IDLE with immediate div start next cycle; the two results are presented in order.
- rst asserted (driven 0) in DIV_BUSY → all outputs 0 without a clock edge; after release, a new MULHU completes normally.
- With MULDIV_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready never asserted → after 8 busy cycles O_timeout=1, O_annul=1, O_result=0xFFFFFFFF with valid; without the macro, stall persists.
